// File: rtl/spi_regfile.sv
// SPI mode-0 slave with a bank of configuration registers, write commit and readback.
// All logic runs on clk; SPI pins are oversampled through two-flop synchronisers.
`timescale 1ns/1ps
module spi_regfile #(
  parameter int              NUM_REGS  = 5,
  parameter int              ADDR_W    = 7,
  parameter int              DATA_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         sdi,
  input  logic                         cs_n,
  output logic                         sdo,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  // state  | meaning
  // IDLE   | waiting for an armed chip-select assertion
  // CMD    | shifting in R/W bit and address
  // DATA   | shifting data field in, readback data out
  // COMMIT | one cycle: apply write or flag a bad frame

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 2);
  localparam int RX_W  = (DATA_W > ADDR_W + 1) ? DATA_W : ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(FRAME + 1);
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(ADDR_W);

  typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;

  state_t state, state_next;

  logic [1:0] sclk_sync, sdi_sync, cs_sync;
  logic sclk_d, cs_d, cs_fall_q, armed;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [CNT_W-1:0]  cnt;
  logic [RX_W-1:0]   rx, rx_next;
  logic              cmd_wr, tx_loaded;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] tx, rd_val;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              addr_ok;
  logic shift_en, decode_en, tx_en, frame_ok, do_write, do_err;

  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign cs_rise   = cs_sync[1] & ~cs_d;
  assign cs_fall   = ~cs_sync[1] & cs_d;
  assign rx_next   = {rx[RX_W-2:0], sdi_sync[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      cs_fall_q <= 1'b0;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      sdi_sync  <= {sdi_sync[0], sdi};
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      cs_fall_q <= cs_fall;
      // Traffic is ignored until chip-select has been seen idle high.
      if (cs_sync[1]) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && cs_rise) state_next = COMMIT;
               else if (armed && cs_fall_q) state_next = CMD;
      CMD:     if (cs_rise) state_next = COMMIT;
               else if (decode_en) state_next = DATA;
      DATA:    if (cs_rise) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shift_en  = (state == CMD || state == DATA) && sclk_rise && !cs_rise;
    decode_en = (state == CMD) && shift_en && (cnt == CNT_CMD);
    tx_en     = (state == DATA) && sclk_fall && !cs_rise && !cmd_wr;
    frame_ok  = (cnt == CNT_FRAME);
    do_write  = (state == COMMIT) && frame_ok && cmd_wr && addr_ok;
    do_err    = (state == COMMIT) && !(frame_ok && (!cmd_wr || addr_ok));
  end

  always_comb begin
    addr_ok = 1'b0;
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == ADDR_W'(i)) begin
        addr_ok = 1'b1;
        rd_val  = mem[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rx        <= '0;
      cmd_wr    <= 1'b0;
      cmd_addr  <= '0;
      tx        <= '0;
      tx_loaded <= 1'b0;
      sdo       <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
    end else begin
      wr_strobe <= do_write;
      frame_err <= do_err;
      if (state == IDLE) begin
        cnt       <= '0;
        tx_loaded <= 1'b0;
      end
      if (shift_en) begin
        rx <= rx_next;
        if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      end
      if (decode_en) begin
        cmd_wr   <= rx_next[ADDR_W];
        cmd_addr <= rx_next[ADDR_W-1:0];
      end
      if (state != DATA) begin
        sdo <= 1'b0;
      end else if (tx_en) begin
        // First falling edge after the address loads the readback word.
        if (!tx_loaded) begin
          tx        <= rd_val;
          sdo       <= rd_val[DATA_W-1];
          tx_loaded <= 1'b1;
        end else begin
          tx  <= {tx[DATA_W-2:0], 1'b0};
          sdo <= tx[DATA_W-2];
        end
      end
      if (do_write) begin
        wr_addr <= cmd_addr;
        for (int i = 0; i < NUM_REGS; i++)
          if (cmd_addr == ADDR_W'(i)) mem[i] <= rx[DATA_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: doc/spi_regfile.md
Name: spi_regfile

Overview:
- Parametrised SPI slave (mode 0) with a bank of NUM_REGS configuration registers and register write/readback.
- Replaces the fixed five-register, write-only SPI receiver in the peripheral control path; register outputs drive downstream blocks directly.
- Frame format, MSB first: 1 R/W bit (1 = write, 0 = read), then ADDR_W address bits, then DATA_W data bits.
- Adds readback on sdo, framing-error reporting and a write strobe.

Parameters:
- NUM_REGS, 5, number of registers, addressed 0..NUM_REGS-1; must be at most 2^ADDR_W.
- ADDR_W, 7, address field width.
- DATA_W, 8, register and data field width.
- RESET_VAL, 0, value loaded into every register on reset (DATA_W bits).

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- sclk  input  1  SPI clock, asynchronous to clk.
- sdi  input  1  SPI data in, asynchronous.
- cs_n  input  1  SPI chip select, active-low, asynchronous.
- sdo  output  1  SPI data out.
- regs  output  NUM_REGS*DATA_W  register bank, flattened; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  output  1  one-clk pulse when a write commits.
- wr_addr  output  ADDR_W  address of the last committed write.
- frame_err  output  1  one-clk pulse when a frame is discarded.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, armed=0, sdo=0, regs all RESET_VAL, wr_strobe=0, wr_addr=0, frame_err=0, bit counter and shift registers cleared. rst has priority over every other event.
- Synchronisers: sclk, sdi and cs_n each pass through 2 clk flops, all clocked by clk; no logic is clocked by sclk.
  - Edges are detected by comparing the synchronised value with a registered copy.
  - sclk high and low times must each be at least 4 clk periods.
- Arming: after reset, or if cs_n is low when rst deasserts, the block ignores traffic until synchronised cs_n is seen high (armed=1). This prevents acting on a partial frame.
- FSM states:
  - IDLE: wait for synchronised cs_n falling while armed -> CMD; counter cleared.
  - CMD: on each sclk rising, shift sdi into rx shift register and increment counter. Counter saturates at FRAME+1, where FRAME = 1+ADDR_W+DATA_W. When counter reaches 1+ADDR_W the command is decoded -> DATA.
  - DATA: continue shifting on sclk rising; sdo updates on sclk falling.
  - Any state: synchronised cs_n rising -> COMMIT.
  - COMMIT: single clk cycle -> IDLE.
- Read path:
  - On the first sclk falling after the address is complete, tx register loads reg[addr] (0 if addr >= NUM_REGS) and sdo drives its MSB.
  - Each later sclk falling shifts left; sdo = tx MSB.
  - sdo = 0 whenever cs_n is high or during a write frame. Data bits on sdi are ignored during a read.
- Commit (COMMIT cycle):
  - Write, counter == FRAME, addr < NUM_REGS: reg[addr] <= data field; wr_addr <= addr; wr_strobe = 1. regs visible the cycle after COMMIT.
  - Read with counter == FRAME: no register change, no pulse.
  - Otherwise (counter != FRAME, or write with addr >= NUM_REGS): frame discarded, frame_err = 1, regs unchanged.
  - cs_n falling with zero sclk edges, then rising: counter 0, frame_err = 1.
- Latency: cs_n rising at pin -> regs updated within 4 clk cycles.
- Simultaneous events:
  - cs_n rising and sclk edge in the same synchronised cycle: cs_n takes priority; the edge is dropped.
  - cs_n falling detected in COMMIT: honoured on the next cycle (the IDLE check uses the registered edge flag).

Test Plan:
- Write: reset, frame 1_0000011_10100101 (addr 3, data 0xA5) at sclk=clk/10 -> reg3=0xA5, wr_strobe one pulse, wr_addr=3, other regs 0, frame_err stays 0.
- Readback: after the write above, read frame 0_0000011_xxxxxxxx -> sdo bits 1,0,1,0,0,1,0,1 sampled on sclk rising edges 9..16; no regs change.
- Bad address: write addr 5 (NUM_REGS=5), data 0xFF -> frame_err pulse, no regs change, read of addr 5 returns 0x00.
- Short/long frame: 15 bits, then 17 bits -> frame_err pulse each, regs unchanged; a following valid write to reg0=0x3C succeeds.
- Reset mid-frame: assert rst after 8 bits of a write to reg1, release with cs_n still low, clock 8 more bits, raise cs_n -> no commit and no frame_err. Next full frame commits normally.
- Parametrisation: NUM_REGS=16, ADDR_W=4, DATA_W=16, RESET_VAL=0x1234 -> all regs reset to 0x1234; 21-bit write of 0xBEEF to addr 15 updates only reg15.
